// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared types and GF(2^8) helpers for the sequential AES-128 key schedule.
// Holds the key width, round count, stream state encoding and S-box math.
package aes_key_schedule_seq_pkg;

  localparam int KW = 128;
  localparam int NR = 10;

  typedef logic [KW-1:0] rkey_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // S-box built from the multiplicative inverse (a^254, so 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] v;
    case (rc)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Control, stream and random-access read signals of the key-schedule block.
// master = consumer/driver side, slave = the key-schedule controller.
interface aes_key_schedule_seq_if;
  import aes_key_schedule_seq_pkg::*;

  logic       start;
  rkey_t      key_in;
  logic       busy;
  logic       done;
  logic       rk_valid;
  logic       rk_ready;
  logic [3:0] rk_idx;
  rkey_t      rk_data;
  logic [3:0] rd_idx;
  rkey_t      rd_data;

  modport master (
    output start, key_in, rk_ready, rd_idx,
    input  busy, done, rk_valid, rk_idx, rk_data, rd_data
  );

  modport slave (
    input  start, key_in, rk_ready, rd_idx,
    output busy, done, rk_valid, rk_idx, rk_data, rd_data
  );

endinterface

// File: rtl/aes_key_schedule_seq_keygen.sv
// Single AES-128 key expansion round: derives round key rc from round key rc-1.
// Purely combinational; the caller keeps rc within 1..10.
module Iterative_key_generation
  import aes_key_schedule_seq_pkg::*;
(
  input  logic [3:0] rc,
  input  rkey_t      key,
  output rkey_t      keyout
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = key[127:96];
  assign w_w1 = key[95:64];
  assign w_w2 = key[63:32];
  assign w_w3 = key[31:0];

  // RotWord then SubWord on the last word, then fold in the round constant.
  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_temp = w_sub ^ {rcon(rc), 24'h000000};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign keyout = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key schedule: expands one round per cycle into an 11-entry
// store, streams the round keys in order and offers random-access reads.
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  aes_key_schedule_seq_if.slave  bus
);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gen_rc;
  logic [3:0] r_out_ptr;
  rkey_t      r_cur_key;
  rkey_t      r_store [0:NR];
  logic       r_done;

  rkey_t      w_nk;
  logic [3:0] w_rc;
  logic [4:0] w_generated;
  logic       w_accept;
  logic       w_xfer;
  logic       w_last;

  // The expander only ever sees a legal round constant index, even while idle.
  assign w_rc = (r_state == EXPAND) ? r_gen_rc : 4'd1;

  Iterative_key_generation u_keygen (
    .rc     (w_rc),
    .key    (r_cur_key),
    .keyout (w_nk)
  );

  // During EXPAND, gen_rc equals the number of entries written so far.
  assign w_generated = (r_state == DRAIN) ? 5'(NR + 1) : {1'b0, r_gen_rc};
  assign w_accept    = (r_state == IDLE) && bus.start;
  assign w_xfer      = bus.rk_valid && bus.rk_ready;
  assign w_last      = w_xfer && (r_out_ptr == 4'(NR));

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.rk_valid = (r_state != IDLE) && ({1'b0, r_out_ptr} < w_generated);
  assign bus.rk_idx   = r_out_ptr;
  assign bus.rk_data  = r_store[r_out_ptr];
  assign bus.rd_data  = (bus.rd_idx <= 4'(NR)) ? r_store[bus.rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = EXPAND;
      EXPAND:  if (w_last) w_state_nxt = IDLE;
               else if (r_gen_rc == 4'(NR)) w_state_nxt = DRAIN;
      DRAIN:   if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset wipes the whole store so no key material survives an abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gen_rc  <= '0;
      r_out_ptr <= '0;
      r_cur_key <= '0;
      r_done    <= 1'b0;
      for (int i = 0; i <= NR; i++) r_store[i] <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_store[0] <= bus.key_in;
        r_cur_key  <= bus.key_in;
        r_gen_rc   <= 4'd1;
        r_out_ptr  <= '0;
      end else begin
        if (r_state == EXPAND) begin
          r_store[r_gen_rc] <= w_nk;
          r_cur_key         <= w_nk;
          if (r_gen_rc != 4'(NR)) r_gen_rc <= r_gen_rc + 4'd1;
        end
        if (w_xfer && (r_out_ptr != 4'(NR))) r_out_ptr <= r_out_ptr + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for the sequential AES-128 key schedule using FIPS-197 vectors.
module tb_aes_key_schedule_seq;
  import aes_key_schedule_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_seq_if bus ();

  aes_key_schedule_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         chk;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] ks1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key1();
    for (int k = 0; k <= 10; k++) sb.push_back('{idx: 4'(k), data: ks1[k], chk: 1'b1});
  endtask

  // Only the published round keys 0, 1 and 10 are data-checked for the second key.
  task automatic push_key2();
    for (int k = 0; k <= 10; k++) begin
      exp_t e;
      e.idx  = 4'(k);
      e.chk  = (k == 0) || (k == 1) || (k == 10);
      e.data = (k == 0) ? KEY2 : (k == 1) ? 128'hd6aa74fdd2af72fadaa678f1d6ab76fe :
               128'h13111d7fe3944a17f307a78b4d2b30c5;
      sb.push_back(e);
    end
  endtask

  task automatic start_run(input logic [127:0] key);
    bus.key_in = key;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!bus.done && cycles < limit) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  // Monitor: pops on every handshake, checks done timing and stall stability.
  logic         pend_done  = 1'b0;
  logic         prev_stall = 1'b0;
  logic [3:0]   prev_idx   = '0;
  logic [127:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("done_pulse", {127'b0, bus.done}, {127'b0, pend_done});
      if (bus.done) begin
        n_done++;
        check("busy_at_done", {127'b0, bus.busy}, 128'd0);
      end
      if (prev_stall) begin
        check("stall_valid", {127'b0, bus.rk_valid}, 128'd1);
        check("stall_idx", {124'b0, bus.rk_idx}, {124'b0, prev_idx});
        check("stall_data", bus.rk_data, prev_data);
      end
      pend_done = 1'b0;
      if (bus.rk_valid && bus.rk_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: unexpected transfer idx %0d", bus.rk_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rk_idx", {124'b0, bus.rk_idx}, {124'b0, e.idx});
          if (e.chk) check("rk_data", bus.rk_data, e.data);
        end
        pend_done = (bus.rk_idx == 4'd10);
      end
      prev_stall = bus.rk_valid && !bus.rk_ready;
      prev_idx   = bus.rk_idx;
      prev_data  = bus.rk_data;
    end else begin
      pend_done  = 1'b0;
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b1;
    bus.rd_idx   = '0;
    rst_n        = 1'b0;
    tick();
    tick();
    check("rst_busy", {127'b0, bus.busy}, 128'd0);
    check("rst_done", {127'b0, bus.done}, 128'd0);
    check("rst_valid", {127'b0, bus.rk_valid}, 128'd0);
    check("rst_idx", {124'b0, bus.rk_idx}, 128'd0);
    check("rst_data", bus.rk_data, 128'd0);
    check("rst_rd", bus.rd_data, 128'd0);
    rst_n = 1'b1;
    tick();

    // Run A: free-flowing stream, one key per cycle.
    push_key1();
    start_run(KEY1);
    check("first_valid", {127'b0, bus.rk_valid}, 128'd1);
    check("first_idx", {124'b0, bus.rk_idx}, 128'd0);
    check("busy_run", {127'b0, bus.busy}, 128'd1);
    wait_done(40, cyc);
    check("run_latency", 128'(cyc), 128'd11);
    tick();

    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      check("rd_sweep", bus.rd_data, (i <= 10) ? ks1[i] : 128'd0);
    end

    // Run B: long stall then alternating ready.
    bus.rk_ready = 1'b0;
    push_key1();
    start_run(KEY1);
    repeat (20) tick();
    for (int i = 0; i < 60 && !bus.done; i++) begin
      bus.rk_ready = i[0];
      tick();
    end
    check("stall_run_done", {127'b0, bus.done}, 128'd1);
    bus.rk_ready = 1'b1;
    tick();

    // Run C: a second start while busy must not disturb the schedule.
    push_key1();
    start_run(KEY1);
    tick();
    bus.key_in = KEY2;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    wait_done(40, cyc);
    tick();
    tick();
    check("no_restart", {127'b0, bus.busy}, 128'd0);
    check("store_kept", dut.bus.rd_data, (bus.rd_idx <= 4'd10) ? ks1[bus.rd_idx] : 128'd0);

    // Run D: reset while gen_rc is 5.
    push_key1();
    start_run(KEY1);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", {127'b0, bus.busy}, 128'd0);
    check("abort_valid", {127'b0, bus.rk_valid}, 128'd0);
    for (int i = 0; i <= 10; i++) begin
      bus.rd_idx = 4'(i);
      #0.5;
      check("abort_rd", bus.rd_data, 128'd0);
    end
    sb.delete();
    tick();

    // Run E with the second key, then Run F back-to-back with no dead cycle.
    push_key2();
    start_run(KEY2);
    wait_done(40, cyc);
    push_key1();
    start_run(KEY1);
    check("b2b_busy", {127'b0, bus.busy}, 128'd1);
    check("b2b_idx0", bus.rk_data, KEY1);
    wait_done(40, cyc);
    repeat (3) tick();

    check("sb_empty", 128'(sb.size()), 128'd0);
    check("done_count", 128'(n_done), 128'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
